// File: rtl/key_matrix16x8_scanner.sv
// 16x8 key matrix scanner: strobes rows one-hot, samples synchronized columns, publishes a 128-bit bitmap per scan.
// Optional frame-level debounce is compiled in with `define KEYSCAN_DEBOUNCE_EN.
module key_matrix16x8_scanner #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scan_en,
  input  logic [15:0]  col_sense,
  output logic [7:0]   row_drive,
  output logic [127:0] keys,
  output logic         frame_done,
  output logic         changed
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  generate
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("SETTLE_CYCLES must be at least 3");
    end
    if (DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
      $error("DEBOUNCE_FRAMES must be within 2..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DRIVE, FRAME_END} state_t;

  state_t         state_reg;
  logic [2:0]     row_idx_reg;
  logic [CW-1:0]  settle_cnt_reg;
  logic [15:0]    sync1_reg;
  logic [15:0]    col_sync_reg;
  logic [127:0]   frame_raw;
  logic           settle_done;
  logic           frame_commit;
  logic           publish;

  assign settle_done  = (settle_cnt_reg == CW'(SETTLE_CYCLES - 1));
  assign frame_commit = (state_reg == DRIVE) && settle_done && (row_idx_reg == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= '0;
      col_sync_reg <= '0;
    end else begin
      sync1_reg    <= col_sense;
      col_sync_reg <= sync1_reg;
    end
  end

  // Rows 0..6 are buffered; row 7 is taken straight from the synchronizer on the
  // commit edge so the finished frame is visible together with frame_done.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_row_buf
      logic [15:0] row_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          row_reg <= '0;
        end else if (state_reg == DRIVE && settle_done && row_idx_reg == 3'(gi)) begin
          row_reg <= col_sync_reg;
        end
      end
      assign frame_raw[127-16*gi -: 16] = row_reg;
    end
  endgenerate
  assign frame_raw[15:0] = col_sync_reg;

`ifdef KEYSCAN_DEBOUNCE_EN
  logic [127:0] prev_raw_reg;
  logic [3:0]   stable_cnt_reg;
  logic [3:0]   stable_cnt_next;

  always_comb begin
    stable_cnt_next = 4'd1;
    if (frame_raw == prev_raw_reg) begin
      stable_cnt_next = (stable_cnt_reg == 4'hF) ? 4'hF : stable_cnt_reg + 4'd1;
    end
  end

  // Equality (not >=) so a long-stable frame is published exactly once.
  assign publish = (stable_cnt_next == 4'(DEBOUNCE_FRAMES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_raw_reg   <= '0;
      stable_cnt_reg <= '0;
    end else if (frame_commit) begin
      prev_raw_reg   <= frame_raw;
      stable_cnt_reg <= stable_cnt_next;
    end
  end
`else
  assign publish = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      row_idx_reg    <= '0;
      settle_cnt_reg <= '0;
      row_drive      <= '0;
      keys           <= '0;
      frame_done     <= 1'b0;
      changed        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      changed    <= 1'b0;
      case (state_reg)
        IDLE: begin
          row_drive <= '0;
          if (scan_en) begin
            state_reg      <= DRIVE;
            row_idx_reg    <= '0;
            settle_cnt_reg <= '0;
            row_drive      <= 8'h01;
          end
        end
        DRIVE: begin
          if (settle_done) begin
            if (row_idx_reg != 3'd7) begin
              row_idx_reg    <= row_idx_reg + 3'd1;
              settle_cnt_reg <= '0;
              row_drive      <= 8'h01 << (row_idx_reg + 3'd1);
            end else begin
              state_reg  <= FRAME_END;
              row_drive  <= '0;
              frame_done <= 1'b1;
              if (publish) begin
                keys    <= frame_raw;
                changed <= (frame_raw != keys);
              end
            end
          end else begin
            settle_cnt_reg <= settle_cnt_reg + CW'(1);
          end
        end
        FRAME_END: begin
          row_idx_reg    <= '0;
          settle_cnt_reg <= '0;
          if (scan_en) begin
            state_reg <= DRIVE;
            row_drive <= 8'h01;
          end else begin
            state_reg <= IDLE;
            row_drive <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          row_drive <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix16x8_scanner.sv
// Randomized bench for key_matrix16x8_scanner: a key-matrix model answers the row strobes and
// a frame-level reference predicts the strobe timing and every published bitmap.
module tb_key_matrix16x8_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int PERIOD = 8 * SETTLE + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scan_en = 1'b0;
  logic [15:0]  col_sense;
  logic [7:0]   row_drive;
  logic [127:0] keys;
  logic         frame_done;
  logic         changed;

  logic [15:0]  matrix [8];
  int           n_checks = 0;
  int           n_errors = 0;
  int           frame_no = 0;
  logic [127:0] exp_keys = '0;
  logic [127:0] last_raw = '0;
  int           run_len = 0;

  key_matrix16x8_scanner #(
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .col_sense (col_sense),
    .row_drive (row_drive),
    .keys      (keys),
    .frame_done(frame_done),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  // Pressed keys of the driven row pull their column lines high.
  always_comb begin
    col_sense = '0;
    for (int i = 0; i < 8; i++) begin
      if (row_drive[i]) col_sense = col_sense | matrix[i];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] matrix_image();
    logic [127:0] img;
    img = '0;
    for (int r = 0; r < 8; r++) img[127-16*r -: 16] = matrix[r];
    return img;
  endfunction

  task automatic set_rows(input logic [15:0] even_v, input logic [15:0] odd_v);
    for (int r = 0; r < 8; r++) matrix[r] = (r % 2 == 0) ? even_v : odd_v;
  endtask

  task automatic model_reset();
    exp_keys = '0;
    last_raw = '0;
    run_len  = 0;
  endtask

  // Entered at the negedge of the first driven cycle; leaves at the frame-end negedge.
  task automatic run_frame(input bit stop_mid);
    logic [127:0] raw;
    logic [7:0]   exp_rd;
    bit           pub;
    logic         exp_chg;
    for (int pos = 0; pos < PERIOD; pos++) begin
      if (pos > 0) @(negedge clk);
      if (pos < PERIOD - 1) begin
        exp_rd = 8'h01 << (pos / SETTLE);
        check("row_drive", 128'(row_drive), 128'(exp_rd));
        check("frame_done_low", 128'(frame_done), 128'(0));
      end
      if (stop_mid && pos == 5 * SETTLE) scan_en = 1'b0;
    end
    raw = matrix_image();
`ifdef KEYSCAN_DEBOUNCE_EN
    if (run_len > 0 && raw == last_raw) run_len++;
    else begin
      run_len  = 1;
      last_raw = raw;
    end
    pub = (run_len == DEB);
`else
    pub = 1'b1;
`endif
    exp_chg = pub && (raw != exp_keys);
    if (pub) exp_keys = raw;
    check("frame_end_row_drive", 128'(row_drive), 128'(0));
    check("frame_done", 128'(frame_done), 128'(1));
    check("keys", keys, exp_keys);
    check("changed", 128'(changed), 128'(exp_chg));
    $display("frame %0d keys=%h changed=%b frame_done=%b", frame_no, keys, changed, frame_done);
    frame_no++;
  endtask

  task automatic wait_first_row(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      if (row_drive == 8'h01) seen = 1'b1;
    end
    check(tag, 128'(seen), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_rows(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_row_drive", 128'(row_drive), 128'(0));
    check("reset_keys", keys, 128'(0));
    check("reset_frame_done", 128'(frame_done), 128'(0));
    check("reset_changed", 128'(changed), 128'(0));

    // Blank matrix: strobe walk and frame_done cadence, changed stays low.
    scan_en = 1'b1;
    wait_first_row("start_row0");
    run_frame(1'b0);
    @(negedge clk);
    run_frame(1'b0);

    // Single key at row 2, column 0 -> bit 95; held for several frames.
    matrix[2] = 16'h8000;
    for (int f = 0; f < 4; f++) begin
      @(negedge clk);
      run_frame(1'b0);
    end

    // Alternating full pattern.
    set_rows(16'hA5A5, 16'h5A5A);
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      run_frame(1'b0);
    end

    // Random matrices, sometimes repeated so unchanged frames are exercised.
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 2) != 0) begin
        for (int r = 0; r < 8; r++)
          matrix[r] = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      end
      @(negedge clk);
      run_frame(1'b0);
    end

    // Drop scan_en during row 5: frame completes, then idles holding keys.
    set_rows(16'h0001, 16'h8000);
    @(negedge clk);
    run_frame(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_row_drive", 128'(row_drive), 128'(0));
      check("idle_frame_done", 128'(frame_done), 128'(0));
      check("idle_keys_hold", keys, exp_keys);
    end

    // Asynchronous reset while row 3 is driven.
    scan_en = 1'b1;
    @(negedge clk);
    check("restart_row0", 128'(row_drive), 128'(8'h01));
    for (int pos = 1; pos <= 3 * SETTLE + 1; pos++) @(negedge clk);
    check("pre_reset_row3", 128'(row_drive), 128'(8'h08));
    rst = 1'b1;
    #1;
    check("async_rst_row_drive", 128'(row_drive), 128'(0));
    check("async_rst_keys", keys, 128'(0));
    check("async_rst_frame_done", 128'(frame_done), 128'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wait_first_row("post_reset_row0");
    run_frame(1'b0);
    set_rows(16'h1234, 16'hFEDC);
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      run_frame(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
